bcd_serial_adder_ctrl: RTL and testbench
========================================

Name: bcd_serial_adder_ctrl

Overview:
- Digit-serial BCD adder controller: time-multiplexes one adder1digit instance across DIGITS packed BCD digits, least significant digit first, one digit per clock.
- Same function as the parallel multi-digit ripple adder: s = a + b + cin in decimal, carry out on cout. Uses one digit adder instead of DIGITS.
- Sits between a requester (start/done handshake) and the packed-BCD operand registers; intended for area-constrained BCD arithmetic paths.

Parameters:
- DIGITS, 3, number of BCD digits per operand (must be >= 1); operand width is 4*DIGITS.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request pulse; accepted only in IDLE or DONE.
- a  input  4*DIGITS  packed BCD operand A; digit i is a[4i+3:4i]; sampled on accept.
- b  input  4*DIGITS  packed BCD operand B; sampled on accept.
- cin  input  1  decimal carry in; sampled on accept.
- busy  output  1  high while digits are being computed (RUN).
- done  output  1  one-cycle pulse; s/cout valid from this cycle.
- s  output  4*DIGITS  packed BCD sum, registered.
- cout  output  1  final decimal carry, registered.
- bcd_err  output  1  set on accept if any digit of a or b > 9.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (rst high at a clock edge): state=IDLE; busy=0, done=0, s=0, cout=0, bcd_err=0; digit index=0. Takes priority over all other inputs, including mid-RUN. The partial result is discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=0: hold outputs.
- IDLE or DONE, start=1 (accept):
  - latch a, b, cin into internal registers;
  - idx <= 0; s <= 0; cout <= 0;
  - bcd_err <= (any a or b digit > 9);
  - -> RUN.
- RUN, each cycle:
  - adder1digit is fed latched a digit idx, b digit idx and the carry register;
  - s digit idx <= digit sum; carry register <= digit carry;
  - if idx == DIGITS-1: cout <= digit carry, -> DONE; else idx <= idx+1.
- DONE:
  - done=1 for exactly one cycle;
  - without start, -> IDLE next cycle;
  - with start, accept (back-to-back) and go straight to RUN.
- Outputs:
  - busy = (state==RUN); done = (state==DONE), registered-state decoded.
- Latency and throughput:
  - accept at edge N; busy high for cycles N+1..N+DIGITS; done high in cycle N+DIGITS+1.
  - throughput: one operation per DIGITS+1 cycles.
- start in RUN: ignored; no queuing, latched operands unchanged.
- Operand changes after accept: no effect on the in-flight operation.
- s, cout and bcd_err hold their values after DONE until the next accept or reset.
- During RUN, s is partially written and only meaningful when done=1.
- Invalid BCD digits:
  - the computation still runs;
  - the s digit value is whatever adder1digit produces;
  - bcd_err flags the operation; it is not a stall.
- DIGITS=1: RUN lasts one cycle.
- idx width: clog2(DIGITS), minimum 1.

Test Plan:
- Reset, then accept a=0x100, b=0x225, cin=0 -> busy high for 3 cycles; done in cycle 4 after accept; s=0x325, cout=0, bcd_err=0.
- a=0x999, b=0x999, cin=0 -> s=0x998, cout=1. Repeat with cin=1 -> s=0x999, cout=1. Issue the second start in the DONE cycle to check back-to-back accept with no idle cycle.
- Accept a=0x123, b=0x456. Pulse start with a=0x999 during RUN -> ignored; result s=0x579, cout=0; only one done pulse.
- Accept a=0x555, b=0x555. Assert rst on the 2nd RUN cycle -> next cycle busy=0, done=0, s=0, cout=0. A later start with 0x001+0x001 gives s=0x002.
- Accept a=0x00A, b=0x000 -> bcd_err=1 from the cycle after accept through done. The next valid operation (0x000+0x000) clears bcd_err to 0.
- DIGITS=1 instance: a=0x9, b=0x1, cin=0 -> done 2 cycles after accept; s=0x0, cout=1.

Source files
------------

// File: rtl/bcd_serial_adder_ctrl.sv
// Digit-serial packed-BCD adder: one adder1digit time-multiplexed over DIGITS
// digits, least significant digit first, one digit per clock.

// Single BCD digit adder with decimal carry correction.
module adder1digit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] sum_c,
  output logic       carry_c
);

  logic [4:0] raw;

  // Binary sum, then add 6 when the result leaves the decimal range.
  always_comb begin
    raw     = 5'(a) + 5'(b) + 5'(ci);
    carry_c = (raw > 5'd9);
    sum_c   = carry_c ? 4'(raw + 5'd6) : raw[3:0];
  end

endmodule

module bcd_serial_adder_ctrl #(
  parameter int unsigned DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                cin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] s,
  output logic                cout,
  output logic                bcd_err
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    a_q, a_nxt;
  logic [W-1:0]    b_q, b_nxt;
  logic            carry_q, carry_nxt;
  logic [IW-1:0]   idx, idx_nxt;
  logic [W-1:0]    s_nxt;
  logic            cout_nxt;
  logic            bcd_err_nxt;

  logic [3:0]      dig_a_c, dig_b_c;
  logic [3:0]      dig_sum_c;
  logic            dig_carry_c;

  // True when any 4-bit digit of the operand exceeds 9.
  function automatic logic any_bad(input logic [W-1:0] v);
    logic r;
    r = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (v[4*i +: 4] > 4'd9) r = 1'b1;
    end
    return r;
  endfunction

  // Select the current digit of each latched operand.
  always_comb begin
    dig_a_c = 4'd0;
    dig_b_c = 4'd0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (idx == IW'(i)) begin
        dig_a_c = a_q[4*i +: 4];
        dig_b_c = b_q[4*i +: 4];
      end
    end
  end

  adder1digit u_digit (
    .a       (dig_a_c),
    .b       (dig_b_c),
    .ci      (carry_q),
    .sum_c   (dig_sum_c),
    .carry_c (dig_carry_c)
  );

  // Next-state and datapath update: accept, per-digit step, completion.
  always_comb begin
    state_nxt   = state;
    a_nxt       = a_q;
    b_nxt       = b_q;
    carry_nxt   = carry_q;
    idx_nxt     = idx;
    s_nxt       = s;
    cout_nxt    = cout;
    bcd_err_nxt = bcd_err;

    unique case (state)
      RUN: begin
        for (int i = 0; i < int'(DIGITS); i++) begin
          if (idx == IW'(i)) s_nxt[4*i +: 4] = dig_sum_c;
        end
        carry_nxt = dig_carry_c;
        if (idx == IW'(DIGITS - 1)) begin
          cout_nxt  = dig_carry_c;
          state_nxt = DONE;
        end else begin
          idx_nxt = idx + IW'(1);
        end
      end
      IDLE, DONE: begin
        if (state == DONE) state_nxt = IDLE;
        if (start) begin
          a_nxt       = a;
          b_nxt       = b;
          carry_nxt   = cin;
          idx_nxt     = '0;
          s_nxt       = '0;
          cout_nxt    = 1'b0;
          bcd_err_nxt = any_bad(a) | any_bad(b);
          state_nxt   = RUN;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and datapath registers; busy/done registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx     <= '0;
      s       <= '0;
      cout    <= 1'b0;
      bcd_err <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      a_q     <= a_nxt;
      b_q     <= b_nxt;
      carry_q <= carry_nxt;
      idx     <= idx_nxt;
      s       <= s_nxt;
      cout    <= cout_nxt;
      bcd_err <= bcd_err_nxt;
      busy    <= (state_nxt == RUN);
      done    <= (state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// Self-checking bench for bcd_serial_adder_ctrl (DIGITS=3 and DIGITS=1).
module tb_bcd_serial_adder_ctrl;

  localparam int D = 3;

  logic        clk = 1'b0;
  logic        rst, start, cin;
  logic [11:0] a, b, s;
  logic        busy, done, cout, bcd_err;

  logic        start1, cin1;
  logic [3:0]  a1, b1, s1;
  logic        busy1, done1, cout1, bcd_err1;

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  bcd_serial_adder_ctrl #(.DIGITS(D)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .s(s), .cout(cout), .bcd_err(bcd_err)
  );

  bcd_serial_adder_ctrl #(.DIGITS(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .s(s1), .cout(cout1), .bcd_err(bcd_err1)
  );

  typedef struct {
    logic [11:0] a;
    logic [11:0] b;
    logic        cin;
    logic [11:0] exp_s;
    logic        exp_cout;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference: convert packed BCD to an integer and do decimal arithmetic.
  function automatic int bcd2int(input logic [11:0] x);
    int r = 0;
    for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(x[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [11:0] int2bcd(input int v);
    logic [11:0] r = '0;
    int t = v;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Issue one operation from IDLE/DONE and wait (bounded) for done.
  task automatic run_op(input logic [11:0] ia, input logic [11:0] ib, input logic ic,
                        output logic [11:0] os, output logic oc,
                        output logic err_first, output logic err_done,
                        output int lat, output int nbusy);
    a = ia; b = ib; cin = ic; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1; nbusy = 0;
    err_first = bcd_err;
    while (!done && lat < 20) begin
      if (busy) nbusy++;
      tick();
      lat++;
    end
    os = s; oc = cout; err_done = bcd_err;
  endtask

  logic [11:0] gs;
  logic        gc, ef, ed;
  int          lat, nb, ref_sum, pulses;
  logic [11:0] ra, rb;
  logic        rc;

  initial begin
    vecs[0] = '{12'h100, 12'h225, 1'b0, 12'h325, 1'b0};
    vecs[1] = '{12'h999, 12'h999, 1'b0, 12'h998, 1'b1};
    vecs[2] = '{12'h999, 12'h999, 1'b1, 12'h999, 1'b1};
    vecs[3] = '{12'h123, 12'h456, 1'b0, 12'h579, 1'b0};
    vecs[4] = '{12'h000, 12'h000, 1'b0, 12'h000, 1'b0};
    vecs[5] = '{12'h500, 12'h499, 1'b1, 12'h000, 1'b1};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_s", 32'(s), 0);
    chk("reset_cout", 32'(cout), 0);
    chk("reset_err", 32'(bcd_err), 0);

    // Table-driven vectors, each started from IDLE.
    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, gs, gc, ef, ed, lat, nb);
      chk($sformatf("vec%0d_s", i), 32'(gs), 32'(vecs[i].exp_s));
      chk($sformatf("vec%0d_cout", i), 32'(gc), 32'(vecs[i].exp_cout));
      chk($sformatf("vec%0d_lat", i), 32'(lat), D + 1);
      chk($sformatf("vec%0d_busy", i), 32'(nb), D);
      chk($sformatf("vec%0d_err", i), 32'(ed), 0);
      tick();
      chk($sformatf("vec%0d_idle", i), 32'({busy, done}), 0);
      chk($sformatf("vec%0d_hold_s", i), 32'(s), 32'(vecs[i].exp_s));
    end

    // Back-to-back: second start issued in the DONE cycle.
    run_op(12'h999, 12'h999, 1'b0, gs, gc, ef, ed, lat, nb);
    chk("b2b_first_s", 32'(gs), 32'h998);
    chk("b2b_first_cout", 32'(gc), 1);
    run_op(12'h999, 12'h999, 1'b1, gs, gc, ef, ed, lat, nb);
    chk("b2b_second_s", 32'(gs), 32'h999);
    chk("b2b_second_cout", 32'(gc), 1);
    chk("b2b_lat", 32'(lat), D + 1);
    chk("b2b_busy", 32'(nb), D);
    tick();

    // Start during RUN is ignored; exactly one done pulse.
    a = 12'h123; b = 12'h456; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    a = 12'h999; b = 12'h999; start = 1'b1;
    tick();
    start = 1'b0;
    pulses = 0;
    gs = '0;
    for (int k = 0; k < 8; k++) begin
      if (done) begin pulses++; gs = s; gc = cout; end
      tick();
    end
    chk("ignore_pulses", 32'(pulses), 1);
    chk("ignore_s", 32'(gs), 32'h579);
    chk("ignore_cout", 32'(gc), 0);

    // Reset on the second RUN cycle discards the operation.
    a = 12'h555; b = 12'h555; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_state", 32'({busy, done}), 0);
    chk("midrst_s", 32'(s), 0);
    chk("midrst_cout", 32'(cout), 0);
    run_op(12'h001, 12'h001, 1'b0, gs, gc, ef, ed, lat, nb);
    chk("after_rst_s", 32'(gs), 32'h002);
    chk("after_rst_lat", 32'(lat), D + 1);
    tick();

    // Invalid digit raises bcd_err for the whole operation; next valid op clears it.
    run_op(12'h00A, 12'h000, 1'b0, gs, gc, ef, ed, lat, nb);
    chk("err_first", 32'(ef), 1);
    chk("err_done", 32'(ed), 1);
    chk("err_lat", 32'(lat), D + 1);
    tick();
    chk("err_hold", 32'(bcd_err), 1);
    run_op(12'h000, 12'h000, 1'b0, gs, gc, ef, ed, lat, nb);
    chk("err_clear", 32'(ed), 0);
    chk("err_clear_s", 32'(gs), 0);
    tick();

    // Randomized valid operands against the decimal model.
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < D; i++) begin
        ra[4*i +: 4] = 4'($urandom_range(9));
        rb[4*i +: 4] = 4'($urandom_range(9));
      end
      rc = 1'($urandom_range(1));
      ref_sum = bcd2int(ra) + bcd2int(rb) + int'(rc);
      run_op(ra, rb, rc, gs, gc, ef, ed, lat, nb);
      chk($sformatf("rnd%0d_s(%h+%h+%0d)", n, ra, rb, rc), 32'(gs), 32'(int2bcd(ref_sum % 1000)));
      chk($sformatf("rnd%0d_cout", n), 32'(gc), 32'(ref_sum >= 1000));
      chk($sformatf("rnd%0d_lat", n), 32'(lat), D + 1);
      if ($urandom_range(1) == 1) tick();
    end

    // DIGITS=1 instance: 9+1 -> 0 carry 1, done two cycles after accept.
    a1 = 4'h9; b1 = 4'h1; cin1 = 1'b0; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("d1_busy", 32'({busy1, done1}), 32'b10);
    tick();
    chk("d1_done", 32'({busy1, done1}), 32'b01);
    chk("d1_s", 32'(s1), 0);
    chk("d1_cout", 32'(cout1), 1);
    chk("d1_err", 32'(bcd_err1), 0);
    tick();
    chk("d1_idle", 32'({busy1, done1}), 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
